// File: rtl/timer_pkg.sv
// Shared constants and helpers for the cascaded modulo timer.
package timer_pkg;

  // Every stage holds an 8-bit value.
  localparam int STAGE_W    = 8;
  // Widest chain the modulus helper can index into.
  localparam int MAX_STAGES = 32;

  // Stage-select width: at least one bit even for a single-stage chain.
  function automatic int sel_w(input int nstages);
    return (nstages <= 1) ? 1 : $clog2(nstages);
  endfunction

  // Modulus of stage k; an 8-bit field of 0 encodes a modulus of 256.
  function automatic int mod_of(input logic [MAX_STAGES*STAGE_W-1:0] moduli,
                                input int k);
    logic [STAGE_W-1:0] field;
    field = moduli[k*STAGE_W +: STAGE_W];
    return (field == 8'd0) ? 256 : int'(field);
  endfunction

endpackage

// File: rtl/timer_stage.sv
// One modulo-MOD up/down counter stage with clamped load.
module timer_stage
  import timer_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               step,
  input  logic               dir,
  input  logic               ld,
  input  logic [STAGE_W-1:0] ld_data,
  output logic [STAGE_W-1:0] value,
  output logic               at_term
);

  // Largest legal value, kept 9 bits wide so MOD=256 compares correctly.
  localparam logic [STAGE_W:0] MAX_V = 9'(MOD - 1);

  logic [STAGE_W-1:0] r_value;
  logic [STAGE_W:0]   w_value_ext;
  logic [STAGE_W-1:0] w_ld_clamped;
  logic               w_at_max;
  logic               w_at_zero;

  assign w_value_ext  = {1'b0, r_value};
  assign w_at_max     = (w_value_ext == MAX_V);
  assign w_at_zero    = (r_value == 8'd0);
  assign w_ld_clamped = ({1'b0, ld_data} > MAX_V) ? MAX_V[STAGE_W-1:0] : ld_data;

  // Terminal value depends on the current direction.
  assign at_term = dir ? w_at_max : w_at_zero;
  assign value   = r_value;

  // Stage register: clear beats load beats step; steps wrap within 0..MOD-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= 8'd0;
    end else if (clr) begin
      r_value <= 8'd0;
    end else if (ld) begin
      r_value <= w_ld_clamped;
    end else if (step) begin
      if (dir) begin
        r_value <= w_at_max ? 8'd0 : r_value + 8'd1;
      end else begin
        r_value <= w_at_zero ? MAX_V[STAGE_W-1:0] : r_value - 8'd1;
      end
    end else begin
      r_value <= r_value;
    end
  end

endmodule

// File: rtl/timer_chain.sv
// Cascade of modulo stages forming a multi-digit timer (e.g. hh:mm:ss).
module timer_chain
  import timer_pkg::*;
#(
  parameter int                        NSTAGES = 3,
  parameter logic [NSTAGES*STAGE_W-1:0] MODULI  = {8'd24, 8'd60, 8'd60},
  parameter bit                        WRAP    = 1'b1,
  localparam int                       SELW    = sel_w(NSTAGES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         dir,
  input  logic                         ld,
  input  logic [SELW-1:0]              ld_sel,
  input  logic [STAGE_W-1:0]           ld_data,
  output logic [NSTAGES*STAGE_W-1:0]   count,
  output logic [NSTAGES-1:0]           carry,
  output logic                         wrap,
  output logic                         done
);

  localparam logic [MAX_STAGES*STAGE_W-1:0] MODULI_EXT = (MAX_STAGES*STAGE_W)'(MODULI);

  logic [NSTAGES-1:0] w_at_term;
  // w_prefix[k] = stages 0..k-1 all at terminal; w_prefix[0] is always true.
  logic [NSTAGES:0]   w_prefix;
  logic               w_chain_term;
  logic               w_tick;
  logic               w_blocked;
  logic               r_wrap;
  logic               r_done;

  assign w_prefix[0]  = 1'b1;
  assign w_chain_term = w_prefix[NSTAGES];
  // A tick only applies when no clear or load claims the cycle.
  assign w_tick       = en & ~ld & ~clr;
  // In stop mode the whole chain freezes once it sits at its terminal.
  assign w_blocked    = (WRAP == 1'b0) & w_chain_term;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    logic w_ld_k;
    logic w_step_k;

    assign w_prefix[k+1] = w_prefix[k] & w_at_term[k];
    assign carry[k]      = en & w_prefix[k+1];
    assign w_ld_k        = ld & (ld_sel == SELW'(k));
    assign w_step_k      = w_tick & w_prefix[k] & ~w_blocked;

    timer_stage #(
      .MOD (mod_of(MODULI_EXT, k))
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .step    (w_step_k),
      .dir     (dir),
      .ld      (w_ld_k),
      .ld_data (ld_data),
      .value   (count[k*STAGE_W +: STAGE_W]),
      .at_term (w_at_term[k])
    );
  end

  // Rollover pulse: set for one cycle after a tick taken at the chain terminal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap <= 1'b0;
    end else if (clr) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_tick & w_chain_term & (WRAP == 1'b1);
    end
  end

  // Sticky done: set by a blocked tick, cleared by clr, ld or a tick that moves count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else if (clr || ld) begin
      r_done <= 1'b0;
    end else if (en) begin
      r_done <= w_blocked;
    end else begin
      r_done <= r_done;
    end
  end

  assign wrap = r_wrap;
  assign done = r_done;

endmodule

// File: tb/tb_timer_chain.sv
// Directed bench for timer_chain: one wrapping and one stopping instance share stimulus.
module tb_timer_chain;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        en;
  logic        dir;
  logic        ld;
  logic [1:0]  ld_sel;
  logic [7:0]  ld_data;

  logic [23:0] count_w, count_s;
  logic [2:0]  carry_w, carry_s;
  logic        wrap_w, wrap_s;
  logic        done_w, done_s;

  int n_cmp;
  int n_bad;

  timer_chain #(.NSTAGES(3), .MODULI({8'd24, 8'd60, 8'd60}), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .dir(dir), .ld(ld),
    .ld_sel(ld_sel), .ld_data(ld_data),
    .count(count_w), .carry(carry_w), .wrap(wrap_w), .done(done_w)
  );

  timer_chain #(.NSTAGES(3), .MODULI({8'd24, 8'd60, 8'd60}), .WRAP(1'b0)) u_stop (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .dir(dir), .ld(ld),
    .ld_sel(ld_sel), .ld_data(ld_data),
    .count(count_s), .carry(carry_s), .wrap(wrap_s), .done(done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] hms(input int h, input int m, input int s);
    return {h[7:0], m[7:0], s[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [7:0] data);
    ld = 1'b1; ld_sel = sel; ld_data = data;
    step();
    ld = 1'b0;
  endtask

  task automatic load_hms(input int h, input int m, input int s);
    load(2'd2, h[7:0]);
    load(2'd1, m[7:0]);
    load(2'd0, s[7:0]);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; clr = 1'b0; en = 1'b0; dir = 1'b1; ld = 1'b0;
    ld_sel = 2'd0; ld_data = 8'd0;
    #12;
    check("rst_count", 32'(count_w), 32'(hms(0, 0, 0)));
    check("rst_wrap",  32'(wrap_w), 32'd0);
    check("rst_done",  32'(done_s), 32'd0);
    rst = 1'b0;
    step();

    // Carry across two stages.
    load_hms(0, 59, 59);
    dir = 1'b1; en = 1'b1;
    #1;
    check("carry_011", 32'(carry_w), 32'h3);
    step();
    en = 1'b0;
    check("tick_010000", 32'(count_w), 32'(hms(1, 0, 0)));
    check("tick_nowrap", 32'(wrap_w), 32'd0);

    // Full rollover upward.
    load_hms(23, 59, 59);
    en = 1'b1;
    #1;
    check("carry_111", 32'(carry_w), 32'h7);
    step();
    check("roll_up_cnt",  32'(count_w), 32'(hms(0, 0, 0)));
    check("roll_up_wrap", 32'(wrap_w), 32'd1);
    check("stop_hold",    32'(count_s), 32'(hms(23, 59, 59)));
    check("stop_done",    32'(done_s), 32'd1);
    check("stop_nowrap",  32'(wrap_s), 32'd0);
    step();
    en = 1'b0;
    check("after_roll_cnt",  32'(count_w), 32'(hms(0, 0, 1)));
    check("after_roll_wrap", 32'(wrap_w), 32'd0);

    // Rollover downward from zero.
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_zero", 32'(count_w), 32'd0);
    check("clr_done", 32'(done_s), 32'd0);
    dir = 1'b0; en = 1'b1;
    step();
    en = 1'b0;
    check("roll_dn_cnt",  32'(count_w), 32'(hms(23, 59, 59)));
    check("roll_dn_wrap", 32'(wrap_w), 32'd1);
    step();
    check("wrap_pulse_end", 32'(wrap_w), 32'd0);

    // Stop mode: blocked ticks hold count and set done; reversing releases.
    clr = 1'b1; step(); clr = 1'b0;
    dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stop_cnt%0d", i),  32'(count_s), 32'd0);
      check($sformatf("stop_done%0d", i), 32'(done_s), 32'd1);
    end
    dir = 1'b1;
    step();
    en = 1'b0;
    check("rev_cnt",  32'(count_s), 32'(hms(0, 0, 1)));
    check("rev_done", 32'(done_s), 32'd0);

    // Load clamp with en asserted: the load wins, seconds untouched.
    en = 1'b1;
    load(2'd1, 8'd75);
    en = 1'b0;
    check("clamp_mm", 32'(count_s), 32'(hms(0, 59, 1)));
    load(2'd2, 8'd200);
    check("clamp_hh", 32'(count_s), 32'(hms(23, 59, 1)));
    load(2'd3, 8'd5);
    check("sel_oob", 32'(count_s), 32'(hms(23, 59, 1)));
    clr = 1'b1;
    load(2'd0, 8'd7);
    clr = 1'b0;
    check("clr_over_ld", 32'(count_s), 32'd0);

    // Asynchronous reset while counting.
    load_hms(12, 34, 56);
    dir = 1'b1; en = 1'b1;
    step();
    check("count_on", 32'(count_w), 32'(hms(12, 34, 57)));
    #2 rst = 1'b1;
    #1;
    check("async_rst_w", 32'(count_w), 32'd0);
    check("async_rst_s", 32'(count_s), 32'd0);
    #1 rst = 1'b0;
    step();
    en = 1'b0;
    check("post_rst_tick", 32'(count_w), 32'(hms(0, 0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_chain.md
# timer_chain

Parametrised cascade of modulo counters forming a multi-digit timer value, e.g. hh:mm:ss with moduli 24/60/60. It sits between the tick generator and the display/compare logic of the timer subsystem. It generalises the single modulo counter with per-stage moduli, up/down counting, per-stage load with clamping, wrap or stop-at-terminal modes, and rollover status.

## Interface

Parameters:

- NSTAGES, 3, number of cascaded stages; stage 0 is least significant.
- MODULI, {8'd24, 8'd60, 8'd60}, packed NSTAGES×8-bit moduli; stage k's modulus is in bits [8k+7:8k]; each modulus is in the range 2..256.
- WRAP, 1, 1 = wrap around at the chain terminal; 0 = stop at the terminal and assert done.

Ports:

- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high; one clock.
- clr  in  1  synchronous clear of all stages to 0.
- en  in  1  tick: step the chain by one.
- dir  in  1  1 = count up, 0 = count down.
- ld  in  1  load strobe.
- ld_sel  in  SELW  stage index to load; SELW = max(1, clog2(NSTAGES)).
- ld_data  in  8  load value.
- count  out  NSTAGES*8  stage values, packed like MODULI.
- carry  out  NSTAGES  combinational; carry[k] = 1 when stage k will roll over on the next tick.
- wrap  out  1  registered; one-cycle pulse when the whole chain rolled over.
- done  out  1  registered, sticky; asserted when WRAP=0 and a tick is blocked at the terminal.

## Operation

- Per-stage terminal value: MOD_k−1 when dir=1; 0 when dir=0.
- Chain terminal: all stages at their terminal value.
- Priority of events: rst (async) > clr > ld > en.
- Tick (en=1, no clr, no ld):
  - Stage 0 steps ±1.
  - Stage k>0 steps when all lower stages are at their terminal value.
  - Up at MOD−1 goes to 0; down at 0 goes to MOD−1.
  - carry[k] = en & (stages 0..k all at terminal).
- Chain terminal with en, WRAP=1:
  - All stages roll over.
  - wrap=1 for exactly the cycle after that edge.
- Chain terminal with en, WRAP=0:
  - count holds; done sets; wrap stays 0.
- done clears on clr, on ld, or on any tick that changes count (e.g. after dir is reversed).
- Load:
  - If ld_sel<NSTAGES, stage ld_sel ← min(ld_data, MOD−1).
  - If ld_sel≥NSTAGES, no write.
  - Other stages hold in either case.
  - en is ignored in a load cycle.
- clr: all stages ← 0; wrap ← 0; done ← 0.
- Stage widths: each stage is 8 bits wide. Comparisons are done at 9-bit width so that MOD=256 works.

## Timing

- Reset values (asynchronous, immediate): count=0, wrap=0, done=0. carry follows from count and en.
- Reset mid-operation zeroes count in the same cycle, regardless of clk.
- Latency:
  - count, wrap and done update on the clk edge that samples en/ld/clr. There is no pipeline.
  - carry is combinational from the current count, dir and en, with zero latency.
- dir may change on any cycle. It takes effect at the next edge, with the terminal values re-evaluated for the new direction.
- Back-to-back ticks every cycle are supported. wrap can pulse on consecutive cycles only if every MOD=… not reachable; minimum wrap spacing is Π MOD_k cycles.

## Structure

- Shared package/include `timer_pkg`:
  - stage width constant (8).
  - SELW computation.
  - function returning MOD_k from MODULI.
- Sub-module `timer_stage`: one modulo up/down stage.
  - Ports: clk, rst, clr, step, dir, ld, ld_data, value, at_term.
  - Parameter: MOD.
  - Performs the load clamp internally.
- Top level generates NSTAGES `timer_stage` instances and contains:
  - the ripple enable (AND of lower at_term);
  - the wrap/done registers;
  - the WRAP mode gating.

## Test plan

Defaults MODULI {24,60,60}, values written hh:mm:ss.

- Load 00:59:59, dir=1, en=1 for 1 cycle → 01:00:00; carry=3'b011 during that cycle; wrap=0.
- WRAP=1: load 23:59:59, tick up → 00:00:00 and wrap=1 for one cycle; next tick → 00:00:01 with wrap=0.
- WRAP=1: from 00:00:00, dir=0, tick → 23:59:59 and wrap=1.
- WRAP=0: at 00:00:00, dir=0, 3 ticks → count holds, done=1 after the first. Then dir=1 and tick → 00:00:01, done=0.
- Load clamp and priority:
  - ld_sel=1, ld_data=75, en=1 in the same cycle → mm=59; ss unchanged (no tick).
  - ld_sel=3 → no change.
  - clr together with ld → all zero.
- Counting at 12:34:56 with en held, assert rst between edges → count=0 immediately. Release rst and tick once → 00:00:01.
